numberle_entry_ctrl: RTL and testbench
======================================

# numberle_entry_ctrl

Controls guess entry for the keypad. It takes the raw 4-bit key code from the keypad scan decoder, debounces it and turns each new key into a single event. Digit keys are collected into a fixed-length guess buffer, and some keys act as edit keys. A finished guess is handed to the game-check logic over a valid/ready handshake. The block sits between the keypad decoder and the guess comparator / seven-segment display driver.

## Interface
- `DIGITS`, 4: digits per guess (1–4).
- `STABLE_CYCLES`, 100000: consecutive identical samples required to accept a key (1 ms at 100 MHz); must be ≥ 2.
- `CNT_W`, 17: debounce counter width; must hold `STABLE_CYCLES`.

Ports:
- `clk`, in, 1: system clock. All state changes on the rising edge.
- `btnR`, in, 1: synchronous, active-high reset.
- `key_code`, in, 4: decoder output. `4'hF` means idle / no key.
- `game_over`, in, 1: level input. While high, entry is locked.
- `guess_ready`, in, 1: the consumer accepts the guess when this and `guess_valid` are both high.
- `guess`, out, 16: BCD buffer. Slot 0 is `[15:12]`. Unused slots read `4'hF`.
- `len`, out, 3: number of digits entered, 0..`DIGITS`.
- `guess_valid`, out, 1: submitted guess is pending.
- `reject`, out, 1: one-cycle pulse when Enter is pressed while `len` < `DIGITS`.
- `locked`, out, 1: high in the LOCKED state.

## Operation
Key map:
- `0`–`9`: digit.
- `B`: backspace.
- `C`: clear all.
- `E`: enter.
- `A` and `D`: ignored.
- `F`: idle (re-arms the debouncer).

Debounce:
- `kc_q` registers `key_code` every cycle.
- The counter clears to 0 when `key_code != kc_q`; otherwise it increments, saturating at `STABLE_CYCLES`.
- An accept occurs on the edge where the counter reaches `STABLE_CYCLES`.
- At accept, if `kc_q == 4'hF`: `last_key <= F` and no event.
- At accept, if `kc_q != last_key`: one-cycle internal `key_evt` with code `kc_q`, and `last_key <= kc_q`.
- At accept, if `kc_q == last_key`: nothing happens. The same key is not repeated until the code returns to F (the decoder holds its last code).

States:
- **ENTRY**
  - Digit with `len < DIGITS`: write to slot `len`, `len++`.
  - Digit with `len == DIGITS`: ignored.
  - `B` with `len > 0`: slot `len-1 <= F`, `len--`.
  - `B` with `len == 0`: ignored.
  - `C`: all slots F, `len <= 0`.
  - `E` with `len == DIGITS`: go to SUBMIT and set `guess_valid`.
  - `E` with `len < DIGITS`: pulse `reject`, buffer unchanged.
- **SUBMIT**
  - `guess_valid` is held high, and `guess`/`len` are frozen. All key events are ignored.
  - On `guess_valid && guess_ready`: clear the buffer and `len`, drop `guess_valid`, return to ENTRY.
- **LOCKED**
  - Entered from ENTRY on any cycle with `game_over=1`.
  - Entered from SUBMIT only after the handshake completes in a cycle where `game_over=1`.
  - All key events are ignored and the buffer is retained for display.
  - Leaves only via `btnR`.

Other rules:
- `game_over` has priority over a same-cycle key event in ENTRY: the event is dropped.
- Reset (any state, mid-debounce or mid-handshake):
  - outputs: `guess=16'hFFFF`, `len=0`, `guess_valid=0`, `reject=0`, `locked=0`;
  - state ENTRY;
  - internal: counter 0, `kc_q=F`, `last_key=F`.
  - A pending guess is discarded without a handshake.

## Timing
- `key_code` changes and is held stable from edge t. `key_evt` is high for the cycle after edge t+`STABLE_CYCLES`. `guess`/`len`/`reject`/state update at edge t+`STABLE_CYCLES`+1.
- A glitch shorter than `STABLE_CYCLES` cycles produces no event.
- `guess_valid` rises at the same edge the Enter takes effect. It falls on the edge after the first cycle with `guess_ready=1`. Minimum high time is 1 cycle. `guess` is stable throughout.
- `reject` is exactly 1 cycle wide.
- `locked` rises on the edge after `game_over` is first sampled high in ENTRY.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Run with `STABLE_CYCLES=4` and `DIGITS=4`.

1. **Digit entry.** Sequence 3,F,7,F,7,F,1, each held 6 cycles → `guess=16'h3771`, `len=4`. A fifth digit 9 → unchanged.
2. **Debounce.**
   - `key_code=5` for 3 cycles, then F → no change.
   - 5 held for 20 cycles without F → exactly one digit is added.
3. **Edit keys.**
   - Enter 1,2 then `B` → `guess=16'h1FFF`, `len=1`.
   - `C` → `16'hFFFF`, `len=0`.
   - `B` at `len=0` → no change.
4. **Reject and submit.**
   - `E` at `len=2` → `reject` high for 1 cycle, buffer kept.
   - Fill to 4, `E` with `guess_ready=0` for 5 cycles → `guess_valid` held, `guess` frozen, digit keys ignored.
   - `guess_ready=1` → `guess_valid` drops next edge, `len=0`, `guess=16'hFFFF`.
5. **Lock.**
   - `game_over=1` during ENTRY with `len=2` → `locked=1`, buffer retained, keys ignored.
   - `btnR` for 1 cycle → all outputs at reset values, entry works again.
6. **Reset mid-operation.** Assert `btnR` while in SUBMIT and while the debounce counter is mid-count → reset values next edge, and no event from the interrupted key.

Source files
------------

// File: rtl/numberle_entry_ctrl.sv
// numberle_entry_ctrl
// Keypad guess-entry controller: debounces the raw key code, turns each new
// key into a one-cycle event, collects digits into a fixed-length BCD buffer,
// applies edit keys and hands a finished guess over a valid/ready handshake.
module numberle_entry_ctrl #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 100000,
  parameter int CNT_W         = 17
) (
  input  logic        clk,
  input  logic        btnR,
  input  logic [3:0]  key_code,
  input  logic        game_over,
  input  logic        guess_ready,
  output logic [15:0] guess,
  output logic [2:0]  len,
  output logic        guess_valid,
  output logic        reject,
  output logic        locked
);

  // Key codes with a special meaning; A and D fall through as ignored.
  localparam logic [3:0] KEY_IDLE  = 4'hF;
  localparam logic [3:0] KEY_BS    = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  localparam logic [CNT_W-1:0] STABLE_L = CNT_W'(STABLE_CYCLES);
  localparam logic [2:0]       DIG_L    = 3'(DIGITS);

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_SUBMIT,
    ST_LOCKED
  } state_t;

  // Debouncer state
  logic [3:0]       kc_q, kc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       last_key_q, last_key_d;
  logic             key_evt_q, key_evt_d;
  logic [3:0]       evt_code_q, evt_code_d;
  logic             accept;

  // Control state and guess buffer; element 0 is the leftmost slot [15:12].
  state_t           state_q, state_d;
  logic [0:3][3:0]  guess_q, guess_d;
  logic [2:0]       len_q, len_d;
  logic             reject_q, reject_d;

  // State register: every flop, synchronous reset on btnR.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update
    // together from pre-edge values; combinational blocks use blocking (=).
    if (btnR) begin
      kc_q       <= KEY_IDLE;
      cnt_q      <= '0;
      last_key_q <= KEY_IDLE;
      key_evt_q  <= 1'b0;
      evt_code_q <= KEY_IDLE;
      state_q    <= ST_ENTRY;
      guess_q    <= '1;
      len_q      <= '0;
      reject_q   <= 1'b0;
    end else begin
      kc_q       <= kc_d;
      cnt_q      <= cnt_d;
      last_key_q <= last_key_d;
      key_evt_q  <= key_evt_d;
      evt_code_q <= evt_code_d;
      state_q    <= state_d;
      guess_q    <= guess_d;
      len_q      <= len_d;
      reject_q   <= reject_d;
    end
  end

  // Debounce: count identical samples, fire one event per newly accepted key.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    kc_d       = key_code;
    cnt_d      = cnt_q;
    last_key_d = last_key_q;
    key_evt_d  = 1'b0;
    evt_code_d = evt_code_q;

    if (key_code != kc_q) begin
      cnt_d = '0;
    end else if (cnt_q != STABLE_L) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Accept only on the transition into the saturated count.
    accept = (cnt_d == STABLE_L) && (cnt_q != STABLE_L);

    if (accept) begin
      if (kc_q == KEY_IDLE) begin
        last_key_d = KEY_IDLE;
      end else if (kc_q != last_key_q) begin
        key_evt_d  = 1'b1;
        evt_code_d = kc_q;
        last_key_d = kc_q;
      end
    end
  end

  // Next-state logic: Enter on a full buffer submits, game_over locks.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ENTRY: begin
        if (game_over) begin
          state_d = ST_LOCKED;
        end else if (key_evt_q && (evt_code_q == KEY_ENTER) && (len_q == DIG_L)) begin
          state_d = ST_SUBMIT;
        end
      end
      ST_SUBMIT: begin
        if (guess_ready) begin
          state_d = game_over ? ST_LOCKED : ST_ENTRY;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  // Output/datapath logic: buffer edits in ENTRY, clear on handshake.
  always_comb begin
    guess_d  = guess_q;
    len_d    = len_q;
    reject_d = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        // game_over wins over a same-cycle key event.
        if (!game_over && key_evt_q) begin
          if (evt_code_q <= KEY_DIGIT_MAX) begin
            if (len_q < DIG_L) begin
              for (int i = 0; i < 4; i++) begin
                if (3'(i) == len_q) guess_d[i] = evt_code_q;
              end
              len_d = len_q + 3'd1;
            end
          end else if (evt_code_q == KEY_BS) begin
            if (len_q != 3'd0) begin
              for (int i = 0; i < 4; i++) begin
                if (3'(i) + 3'd1 == len_q) guess_d[i] = KEY_IDLE;
              end
              len_d = len_q - 3'd1;
            end
          end else if (evt_code_q == KEY_CLR) begin
            guess_d = '1;
            len_d   = '0;
          end else if (evt_code_q == KEY_ENTER) begin
            if (len_q != DIG_L) reject_d = 1'b1;
          end
        end
      end
      ST_SUBMIT: begin
        if (guess_ready) begin
          guess_d = '1;
          len_d   = '0;
        end
      end
      default: begin
        // LOCKED keeps the buffer for display.
      end
    endcase
  end

  assign guess       = guess_q;
  assign len         = len_q;
  assign reject      = reject_q;
  assign guess_valid = (state_q == ST_SUBMIT);
  assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_numberle_entry_ctrl.sv
// Directed bench for numberle_entry_ctrl with STABLE_CYCLES=4, DIGITS=4.
module tb_numberle_entry_ctrl;

  logic        clk = 1'b0;
  logic        btnR;
  logic [3:0]  key_code;
  logic        game_over;
  logic        guess_ready;
  logic [15:0] guess;
  logic [2:0]  len;
  logic        guess_valid;
  logic        reject;
  logic        locked;

  int n_vec = 0;
  int n_err = 0;
  int rej_seen = 0;
  int rej_before;

  numberle_entry_ctrl #(
    .DIGITS       (4),
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clk        (clk),
    .btnR       (btnR),
    .key_code   (key_code),
    .game_over  (game_over),
    .guess_ready(guess_ready),
    .guess      (guess),
    .len        (len),
    .guess_valid(guess_valid),
    .reject     (reject),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Total number of cycles reject has been seen high.
  always @(negedge clk) if (reject) rej_seen++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Hold a code for n edges, then settle 1 time unit past the last edge.
  task automatic hold_key(input logic [3:0] k, input int n);
    key_code = k;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full key press: key then idle, each long enough to be accepted.
  task automatic tap(input logic [3:0] k);
    hold_key(k, 6);
    hold_key(4'hF, 6);
  endtask

  task automatic check_buf(input string tag, input logic [15:0] g, input logic [2:0] l);
    check({tag, "_guess"}, guess, g);
    check({tag, "_len"}, {13'd0, len}, {13'd0, l});
  endtask

  initial begin
    btnR = 1'b1; key_code = 4'hF; game_over = 1'b0; guess_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_buf("rst", 16'hFFFF, 3'd0);
    check("rst_valid", {15'd0, guess_valid}, 16'd0);
    check("rst_reject", {15'd0, reject}, 16'd0);
    check("rst_locked", {15'd0, locked}, 16'd0);
    btnR = 1'b0;
    hold_key(4'hF, 6);

    // 1. Digit entry, fifth digit ignored
    tap(4'h3); tap(4'h7); tap(4'h7); tap(4'h1);
    check_buf("entry", 16'h3771, 3'd4);
    tap(4'h9);
    check_buf("entry_full", 16'h3771, 3'd4);

    // 2. Debounce: short glitch, then long hold gives one digit
    tap(4'hC);
    hold_key(4'h5, 3);
    hold_key(4'hF, 6);
    check_buf("glitch", 16'hFFFF, 3'd0);
    hold_key(4'h5, 20);
    hold_key(4'hF, 6);
    check_buf("long_hold", 16'h5FFF, 3'd1);

    // 3. Edit keys
    tap(4'hC); tap(4'h1); tap(4'h2); tap(4'hB);
    check_buf("bs", 16'h1FFF, 3'd1);
    tap(4'hC);
    check_buf("clr", 16'hFFFF, 3'd0);
    tap(4'hB);
    check_buf("bs_empty", 16'hFFFF, 3'd0);

    // 4. Reject and submit
    tap(4'h1); tap(4'h2);
    rej_before = rej_seen;
    tap(4'hE);
    check("reject_pulse", 16'(rej_seen - rej_before), 16'd1);
    check_buf("reject_keep", 16'h12FF, 3'd2);
    check("reject_novalid", {15'd0, guess_valid}, 16'd0);
    tap(4'h3); tap(4'h4);
    tap(4'hE);
    check("submit_valid", {15'd0, guess_valid}, 16'd1);
    tap(4'h9);
    check_buf("submit_frozen", 16'h1234, 3'd4);
    check("submit_hold", {15'd0, guess_valid}, 16'd1);
    guess_ready = 1'b1;
    @(negedge clk);
    check("hs_before_edge", {15'd0, guess_valid}, 16'd1);
    @(posedge clk);
    #1;
    guess_ready = 1'b0;
    check("hs_valid_drop", {15'd0, guess_valid}, 16'd0);
    check_buf("hs_clear", 16'hFFFF, 3'd0);

    // 5. Lock, then reset out of it
    tap(4'h6); tap(4'h8);
    game_over = 1'b1;
    @(posedge clk);
    #1;
    check("lock_rise", {15'd0, locked}, 16'd1);
    tap(4'h9); tap(4'hC);
    check_buf("lock_keep", 16'h68FF, 3'd2);
    game_over = 1'b0;
    hold_key(4'hF, 3);
    check("lock_sticky", {15'd0, locked}, 16'd1);
    btnR = 1'b1;
    @(posedge clk);
    #1;
    btnR = 1'b0;
    check_buf("unlock_rst", 16'hFFFF, 3'd0);
    check("unlock_locked", {15'd0, locked}, 16'd0);
    check("unlock_valid", {15'd0, guess_valid}, 16'd0);
    tap(4'h7);
    check_buf("after_unlock", 16'h7FFF, 3'd1);

    // 6. Reset while in SUBMIT, then reset mid-debounce
    tap(4'h1); tap(4'h2); tap(4'h3);
    tap(4'hE);
    check("pre_rst_valid", {15'd0, guess_valid}, 16'd1);
    btnR = 1'b1;
    @(posedge clk);
    #1;
    btnR = 1'b0;
    check("rst_submit_valid", {15'd0, guess_valid}, 16'd0);
    check_buf("rst_submit", 16'hFFFF, 3'd0);
    key_code = 4'h4;
    repeat (3) @(posedge clk);
    #1;
    btnR = 1'b1;
    @(posedge clk);
    #1;
    btnR = 1'b0;
    key_code = 4'hF;
    hold_key(4'hF, 10);
    check_buf("rst_debounce", 16'hFFFF, 3'd0);
    check("reject_total", 16'(rej_seen), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
